// File: rtl/data_mem_pkg.sv
// Shared definitions for the RISC-Net data memory unit.
//   - Access-mode encodings carried on req_mode.
//   - Controller state encoding.
//   - byte_lane(): maps a big-endian byte offset within a word onto the
//     physical lane of the byte RAM bank.
package data_mem_pkg;

  localparam logic [1:0] MODE_WORD   = 2'b00;
  localparam logic [1:0] MODE_BYTE_U = 2'b01;
  localparam logic [1:0] MODE_BYTE_S = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bank lane i holds bits [8i+7:8i] of a row. The lowest address of a word
  // is its most significant byte, so offset k lives in lane bytes-1-k.
  function automatic int byte_lane(input int offset, input int bytes);
    return bytes - 1 - offset;
  endfunction

endpackage

// File: rtl/byte_ram_bank.sv
// Single-port synchronous byte RAM organised as ROWS rows of BYTES lanes.
// Pure storage: no reset, no control or error logic.
// Ports:
//   clk      in   clock
//   rd_en    in   capture the addressed row into the read register
//   wr_lane  in   per-lane write enables for the addressed row
//   row      in   row index
//   wdata    in   write data, lane i on bits [8i+7:8i]
//   rdata    out  registered read data, same lane layout as wdata
module byte_ram_bank #(
  parameter int BYTES = 2,
  parameter int ROWS  = 1024,
  parameter int ROW_W = 10
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [BYTES-1:0]     wr_lane,
  input  logic [ROW_W-1:0]     row,
  input  logic [8*BYTES-1:0]   wdata,
  output logic [8*BYTES-1:0]   rdata
);

  logic [BYTES-1:0][7:0] mem [ROWS];
  logic [8*BYTES-1:0]    rdata_q, rdata_d;

  // The read register only updates on a read, so it keeps the last loaded
  // row between accesses.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[row];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (wr_lane[i]) begin
        mem[row][i] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed, big-endian data memory for the RISC-Net load/store stage.
// One request is accepted at a time through a valid/ready handshake, the
// access commits LATENCY edges after acceptance, and a one-cycle response
// pulse follows. Misaligned, out-of-range and reserved-mode requests are
// answered with resp_err and never touch storage.
// Parameter constraints: DATA_W a multiple of 8 and >= 16, DEPTH_BYTES a
// multiple of DATA_W/8 and <= 2**ADDR_W, LATENCY >= 1.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    request present
//   req_ready    request can be accepted this cycle (IDLE and not in reset)
//   req_we       1 = store, 0 = load
//   req_mode     00 word, 01 byte unsigned, 10 byte signed, 11 reserved
//   req_addr     byte address; a word's MSB byte sits at req_addr
//   req_wdata    store data; byte stores use bits [7:0]
//   resp_valid   one-cycle response pulse
//   resp_rdata   load data, held between responses
//   resp_err     request rejected, held between responses
module data_memory_unit
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH_BYTES = 2048,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int BYTES  = DATA_W / 8;
  localparam int ROWS   = DEPTH_BYTES / BYTES;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hold_rdata_q, hold_rdata_d;
  logic                hold_err_q, hold_err_d;

  logic [ADDR_W:0]     addr_ext;
  logic [ROW_W-1:0]    row;
  logic [LANE_W-1:0]   offset;
  int                  lane_sel;
  logic                req_err;
  logic                commit;
  logic                bank_rd_en;
  logic [BYTES-1:0]    bank_wr_lane;
  logic [DATA_W-1:0]   bank_wdata;
  logic [DATA_W-1:0]   bank_rdata;
  logic [7:0]          rd_byte;
  logic [DATA_W-1:0]   cur_rdata;

  // Address decode of the latched request. The extra top bit keeps
  // addr+BYTES from wrapping, so overflow past the end is always caught.
  assign addr_ext = {1'b0, addr_q};
  assign row      = ROW_W'(addr_q / ADDR_W'(BYTES));
  assign offset   = LANE_W'(addr_q % ADDR_W'(BYTES));
  assign lane_sel = byte_lane(int'(offset), BYTES);
  assign commit   = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    req_err = 1'b0;
    if (mode_q == MODE_RSVD) begin
      req_err = 1'b1;
    end else if (mode_q == MODE_WORD) begin
      if ((offset != '0) ||
          (addr_ext + (ADDR_W+1)'(BYTES) > (ADDR_W+1)'(DEPTH_BYTES))) begin
        req_err = 1'b1;
      end
    end else if (addr_ext >= (ADDR_W+1)'(DEPTH_BYTES)) begin
      req_err = 1'b1;
    end
  end

  // Bank control. Writes are suppressed when reset coincides with the
  // commit edge so an aborted store leaves memory untouched. Byte stores
  // replicate the byte on every lane and enable only the addressed one.
  always_comb begin
    bank_rd_en   = commit && !we_q && !req_err;
    bank_wr_lane = '0;
    bank_wdata   = wdata_q;
    if (commit && we_q && !req_err && !rst) begin
      if (mode_q == MODE_WORD) begin
        bank_wr_lane = '1;
      end else begin
        bank_wdata = {BYTES{wdata_q[7:0]}};
        for (int i = 0; i < BYTES; i++) begin
          bank_wr_lane[i] = (i == lane_sel);
        end
      end
    end
  end

  byte_ram_bank #(
    .BYTES (BYTES),
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_bank (
    .clk     (clk),
    .rd_en   (bank_rd_en),
    .wr_lane (bank_wr_lane),
    .row     (row),
    .wdata   (bank_wdata),
    .rdata   (bank_rdata)
  );

  // Response data for the request in flight: read data arrives from the
  // bank's register during RESP; stores and errors answer with zero.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (i == lane_sel) begin
        rd_byte = bank_rdata[8*i +: 8];
      end
    end
    cur_rdata = '0;
    if (!we_q && !req_err) begin
      case (mode_q)
        MODE_WORD:   cur_rdata = bank_rdata;
        MODE_BYTE_U: cur_rdata = {{(DATA_W-8){1'b0}}, rd_byte};
        MODE_BYTE_S: cur_rdata = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
        default:     cur_rdata = '0;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? cur_rdata : hold_rdata_q;
  assign resp_err   = resp_valid ? req_err : hold_err_q;

  // Controller: IDLE latches a request, WAIT counts down to the commit
  // edge, RESP presents the answer for one cycle and snapshots it so the
  // outputs hold until the next response.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          mode_d  = req_mode;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        hold_rdata_d = cur_rdata;
        hold_err_d   = req_err;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      mode_q       <= MODE_WORD;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_rdata_q <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
    end
  end

endmodule
